// File: rtl/keypad_bcd_encoder.sv
// 4x4 matrix keypad scanner with debounce, ghost rejection and key-to-code decode.
// Optional `KEYPAD_AUTOREPEAT_EN re-emits a held key every REPEAT_CYCLES cycles.
module keypad_bcd_encoder #(
  parameter int unsigned SCAN_DIV        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned REPEAT_CYCLES   = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] BCD_output,
  output logic       key_valid
);

  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} state_t;

  state_t          state;
  logic [3:0]      row_meta;
  logic [3:0]      rows_s;
  logic [3:0]      cap_rows;
  logic [1:0]      cap_row;
  logic [1:0]      col_idx;
  logic [SW-1:0]   scan_cnt;
  logic [DW-1:0]   deb_cnt;
  logic [DW-1:0]   rel_cnt;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  logic [RW-1:0]   rpt_cnt;
`else
  // REPEAT_CYCLES has no function in this build
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_CYCLES;
`endif

  function automatic logic one_low(input logic [3:0] r);
    logic [3:0] z;
    z = ~r;
    return (z != 4'd0) && ((z & (z - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!r[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'd1;   4'h1: code = 4'd2;   4'h2: code = 4'd3;   4'h3: code = 4'hA;
      4'h4: code = 4'd4;   4'h5: code = 4'd5;   4'h6: code = 4'd6;   4'h7: code = 4'hB;
      4'h8: code = 4'd7;   4'h9: code = 4'd8;   4'hA: code = 4'd9;   4'hB: code = 4'hC;
      4'hC: code = 4'hE;   4'hD: code = 4'd0;   4'hE: code = 4'hF;   default: code = 4'hD;
    endcase
    return code;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      row_meta   <= 4'hF;
      rows_s     <= 4'hF;
      state      <= SCAN;
      cap_rows   <= 4'hF;
      cap_row    <= 2'd0;
      col_idx    <= 2'd0;
      col_out    <= 4'b1110;
      scan_cnt   <= '0;
      deb_cnt    <= '0;
      rel_cnt    <= '0;
      BCD_output <= 4'd0;
      key_valid  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_cnt    <= '0;
`endif
    end else begin
      row_meta  <= row_in;
      rows_s    <= row_meta;
      key_valid <= 1'b0;
      case (state)
        // Sample at the end of each column dwell; only a single low row is a key.
        SCAN: begin
          if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            if (one_low(rows_s)) begin
              cap_rows <= rows_s;
              cap_row  <= low_idx(rows_s);
              deb_cnt  <= '0;
              state    <= DEBOUNCE;
            end else begin
              col_idx <= col_idx + 2'd1;
              col_out <= col_drive(col_idx + 2'd1);
            end
          end else begin
            scan_cnt <= scan_cnt + SW'(1);
          end
        end
        DEBOUNCE: begin
          if (rows_s != cap_rows) begin
            deb_cnt  <= '0;
            scan_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
            col_out  <= col_drive(col_idx + 2'd1);
            state    <= SCAN;
          end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            deb_cnt    <= '0;
            key_valid  <= 1'b1;
            BCD_output <= decode(cap_row, col_idx);
            state      <= EMIT;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        EMIT: begin
          rel_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
          // The emit cycle itself is the first held cycle of the repeat period.
          rpt_cnt <= RW'(1);
`endif
          state   <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (rows_s == 4'hF) begin
            if (rel_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
              rel_cnt  <= '0;
              scan_cnt <= '0;
              col_idx  <= col_idx + 2'd1;
              col_out  <= col_drive(col_idx + 2'd1);
              state    <= SCAN;
            end else begin
              rel_cnt <= rel_cnt + DW'(1);
            end
          end else begin
            rel_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (rows_s == cap_rows) begin
              if (rpt_cnt == RW'(REPEAT_CYCLES - 1)) begin
                key_valid  <= 1'b1;
                BCD_output <= decode(cap_row, col_idx);
                state      <= EMIT;
              end else begin
                rpt_cnt <= rpt_cnt + RW'(1);
              end
            end else begin
              rpt_cnt <= '0;
            end
`endif
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Scoreboard bench for keypad_bcd_encoder: a keypad model drives rows from col_out,
// expected codes are queued at press time and a monitor checks each key_valid pulse.
module tb_keypad_bcd_encoder;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] BCD_output;
  logic       key_valid;

  logic [15:0] pressed;
  logic [3:0]  exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse_cyc = 0;
  int pulse_gap = 0;

  keypad_bcd_encoder dut (
    .CLK        (CLK),
    .RST        (RST),
    .row_in     (row_in),
    .col_out    (col_out),
    .BCD_output (BCD_output),
    .key_valid  (key_valid)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Passive keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
  end

  task automatic check(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (key_valid) begin
      pulses++;
      pulse_gap = cyc - last_pulse_cyc;
      last_pulse_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got code %0d expected no pulse (t=%0t)", BCD_output, $time);
      end else begin
        check("pulse_code", int'(BCD_output), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_pulse(input int p0, input int budget);
    for (int k = 0; k < budget && pulses == p0; k++) @(negedge CLK);
    check("pulse_seen", int'(pulses != p0), 1);
  endtask

  task automatic press_key(input int r, input int c, input logic [3:0] code);
    int p0;
    p0 = pulses;
    exp_q.push_back(code);
    pressed = 16'(1) << (r*4 + c);
    wait_pulse(p0, 60);
    repeat (10) @(negedge CLK);
    pressed = '0;
    repeat (16) @(negedge CLK);
    check("single_pulse", pulses - p0, 1);
    check("hold_code", int'(BCD_output), int'(code));
  endtask

  int kr[9]    = '{1, 0, 1, 2, 3, 3, 3, 2, 0};
  int kc[9]    = '{3, 1, 2, 1, 1, 0, 2, 3, 3};
  int kcode[9] = '{11, 2, 6, 8, 0, 14, 15, 12, 10};

  initial begin
    int p0;
    int found;
    RST = 1'b1;
    pressed = '0;
    repeat (3) @(negedge CLK);

    check("rst_col", int'(col_out), 14);
    check("rst_bcd", int'(BCD_output), 0);
    check("rst_valid", int'(key_valid), 0);

    // Idle rotation with 4-cycle dwell.
    RST = 1'b0;
    for (int k = 1; k < 40; k++) begin
      @(negedge CLK);
      check("idle_col", int'(col_out), 15 ^ (1 << ((k / 4) % 4)));
      check("idle_valid", int'(key_valid), 0);
    end
    check("idle_bcd", int'(BCD_output), 0);

    for (int i = 0; i < 9; i++) press_key(kr[i], kc[i], 4'(kcode[i]));

    // Bouncing press on row0/col0.
    p0 = pulses;
    exp_q.push_back(4'd1);
    pressed = 16'h0001;
    repeat (5) @(negedge CLK);
    pressed = '0;
    repeat (2) @(negedge CLK);
    check("bounce_no_early", pulses - p0, 0);
    pressed = 16'h0001;
    wait_pulse(p0, 80);
    repeat (10) @(negedge CLK);
    pressed = '0;
    repeat (16) @(negedge CLK);
    check("bounce_single", pulses - p0, 1);
    check("bounce_hold", int'(BCD_output), 1);

    // Ghost: rows 0 and 2 low together on col1.
    p0 = pulses;
    pressed = 16'h0202;
    repeat (40) @(negedge CLK);
    check("ghost_no_pulse", pulses - p0, 0);
    pressed = '0;
    repeat (16) @(negedge CLK);

    // Reset at debounce count 6.
    p0 = pulses;
    pressed = 16'h0020;
    found = 0;
    for (int k = 0; k < 60 && found == 0; k++) begin
      @(negedge CLK);
      if (int'(dut.deb_cnt) == 6) found = 1;
    end
    check("deb6_reached", found, 1);
    RST = 1'b1;
    pressed = '0;
    @(negedge CLK);
    RST = 1'b0;
    check("abort_col", int'(col_out), 14);
    check("abort_bcd", int'(BCD_output), 0);
    check("abort_valid", int'(key_valid), 0);
    repeat (30) @(negedge CLK);
    check("abort_no_pulse", pulses - p0, 0);

    // Long hold on row3/col3.
    p0 = pulses;
    exp_q.push_back(4'hD);
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_q.push_back(4'hD);
    exp_q.push_back(4'hD);
`endif
    pressed = 16'h8000;
    wait_pulse(p0, 60);
    repeat (150) @(negedge CLK);
    pressed = '0;
    repeat (16) @(negedge CLK);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("repeat_count", pulses - p0, 3);
    check("repeat_gap", pulse_gap, 64);
`else
    check("hold_single", pulses - p0, 1);
`endif
    check("hold_bcd", int'(BCD_output), 13);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/keypad_bcd_encoder.md
KEYPAD_BCD_ENCODER -- requirements
Module: keypad_bcd_encoder

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each column stays driven during scanning.
REQ-002 Parameter DEBOUNCE_CYCLES, default 8: consecutive stable samples required to accept a press or a release.
REQ-003 Parameter REPEAT_CYCLES, default 64: cycles a key must be held before it is emitted again; used only when KEYPAD_AUTOREPEAT_EN is defined.
REQ-004 CLK  input  1  system clock; every register SHALL update on its rising edge.
REQ-005 RST  input  1  reset; synchronous and active-high.
REQ-006 row_in  input  4  keypad rows; active-low; asynchronous to CLK.
REQ-007 col_out  output  4  keypad column drive; active-low; one-hot-low during scanning.
REQ-008 BCD_output  output  4  code of the accepted key; feeds management BCD_input.
REQ-009 key_valid  output  1  one-cycle strobe marking a new BCD_output code.

Function
REQ-010 row_in SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rows_s.
REQ-011 The FSM SHALL have four states: SCAN, DEBOUNCE, EMIT, WAIT_RELEASE.
REQ-012 SCAN behaviour:
- col_out cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing every SCAN_DIV cycles.
- rows_s is sampled on the last cycle of each dwell.
REQ-013 In SCAN, exactly one low bit in rows_s SHALL capture (row, col) and move the FSM to DEBOUNCE with col_out frozen.
- Zero low bits, or two or more low bits (ghost or multi-key), SHALL leave the FSM in SCAN and advance the column.
REQ-014 DEBOUNCE behaviour:
- Count consecutive cycles in which rows_s equals the captured pattern.
- When the count reaches DEBOUNCE_CYCLES, go to EMIT.
- Any mismatch first clears the counter, then returns the FSM to SCAN at the next column.
REQ-015 EMIT SHALL last exactly one cycle: key_valid=1 and BCD_output is set to the decoded code in that same cycle; the FSM then goes to WAIT_RELEASE.
REQ-016 Decode table by (row, col):
- row0: 1, 2, 3, 1010
- row1: 4, 5, 6, 1011
- row2: 7, 8, 9, 1100
- row3: 1110, 0000, 1111, 1101
REQ-017 BCD_output SHALL hold the last emitted code until the next EMIT; key_valid SHALL be 0 in every state except EMIT.
REQ-018 WAIT_RELEASE behaviour:
- col_out stays frozen.
- Once rows_s=1111 for DEBOUNCE_CYCLES consecutive cycles, go to SCAN at the next column.
- Any low row clears the release counter.
REQ-019 A key that changes while held, without a full release, SHALL NOT produce a new emission.
REQ-020 Counters SHALL be sized by $clog2 of their parameter and SHALL saturate, never wrap.

Reset
REQ-021 While RST=1 at a rising edge, the block SHALL enter this state on that edge:
- State=SCAN, col_out=1110, BCD_output=0000, key_valid=0.
- All counters and both synchronizer stages set to their idle values (synchronizer stages = 1111).
REQ-022 RST asserted in any state, including mid-debounce or during EMIT, SHALL abort the operation without emitting a code.

Configuration
REQ-023 Macro KEYPAD_AUTOREPEAT_EN, when defined:
- In WAIT_RELEASE, a key held unchanged for REPEAT_CYCLES cycles SHALL return the FSM to EMIT, re-emitting the same code.
- The hold counter restarts after every emission.
REQ-024 Without KEYPAD_AUTOREPEAT_EN, each press SHALL emit exactly once, and REPEAT_CYCLES logic SHALL be absent.

Verification
REQ-025 Reset, no keys pressed for 40 cycles -> col_out rotates 1110, 1101, 1011, 0111 at 4-cycle dwell; key_valid stays 0; BCD_output=0000.
REQ-026 Row1/col3 held low for 30 cycles, then released -> exactly one key_valid pulse with BCD_output=1011, after sync (2) + debounce (8) cycles; BCD_output then holds 1011.
REQ-027 Row0/col0 held for 5 cycles, released for 2, held again -> no emission until an unbroken 8-cycle stable run, then exactly one pulse with 0001.
REQ-028 Rows 0 and 2 both low while col1 is driven -> no key_valid; scanning continues.
REQ-029 RST pulsed at debounce count 6 -> no key_valid; col_out=1110 and BCD_output=0000 on the next cycle.
REQ-030 KEYPAD_AUTOREPEAT_EN defined, row3/col3 held 200 cycles -> first pulse with 1101, then one more pulse every 64 cycles; not defined -> a single pulse only.
